// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// instruction_fetch : PC owner and requester side of a synchronous imem read,
//                     with stall hold buffer and branch/jump redirect.
// Revision: 1.0
// ============================================================================
module instruction_fetch #(
    parameter int unsigned       PC_W     = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [PC_W-1:0]   PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_pc,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   inst_pc
);

    logic [PC_W-1:0]   pc_q;
    logic              pend_v;
    logic [PC_W-1:0]   pend_pc;
    logic              hold_v;
    logic [INST_W-1:0] hold_inst;
    logic [PC_W-1:0]   hold_pc;

    assign imem_pc    = pc_q;
    assign inst_valid = hold_v | pend_v;

    // The hold buffer takes precedence: while it is full, imem_inst belongs
    // to the next PC and must not be shown yet.
    always_comb begin
        inst_out = '0;
        inst_pc  = '0;
        if (hold_v) begin
            inst_out = hold_inst;
            inst_pc  = hold_pc;
        end else if (pend_v) begin
            inst_out = imem_inst;
            inst_pc  = pend_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            pend_v    <= 1'b0;
            pend_pc   <= '0;
            hold_v    <= 1'b0;
            hold_inst <= '0;
            hold_pc   <= '0;
        end else if (redirect_valid) begin
            pc_q   <= redirect_pc;
            pend_v <= 1'b0;
            hold_v <= 1'b0;
        end else if (stall && inst_valid) begin
            // Memory has no address enable, so it keeps re-reading pc_q;
            // capture the stalled word once and keep pend tracking pc_q.
            pend_v  <= 1'b1;
            pend_pc <= pc_q;
            if (!hold_v) begin
                hold_v    <= 1'b1;
                hold_inst <= imem_inst;
                hold_pc   <= pend_pc;
            end
        end else begin
            pc_q    <= pc_q + PC_STEP;
            pend_v  <= 1'b1;
            pend_pc <= pc_q;
            hold_v  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch : directed stimulus with an instruction-stream model.
// Revision: 1.0
// ============================================================================
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    int vectors     = 0;
    int miscompares = 0;

    instruction_fetch #(
        .PC_W    (32),
        .INST_W  (32),
        .RESET_PC(32'd0),
        .PC_STEP (32'd1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_pc       (imem_pc),
        .imem_inst     (imem_inst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: mem[i] = A000_0000 + i
    always @(posedge clk) imem_inst <= 32'hA000_0000 + imem_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: which PC decode should see, and where fetching resumes
    // after a flush.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_target;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_pc     <= 32'd0;
            m_target <= 32'd0;
        end else if (redirect_valid) begin
            m_valid  <= 1'b0;
            m_target <= redirect_pc;
        end else if (m_valid && stall) begin
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_pc <= m_pc + 32'd1;
        end else begin
            m_valid <= 1'b1;
            m_pc    <= m_target;
        end
    end

    always @(negedge clk) begin
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("inst_pc", inst_pc, m_valid ? m_pc : 32'd0);
        chk("inst_out", inst_out, m_valid ? 32'hA000_0000 + m_pc : 32'd0);
        chk("imem_pc", imem_pc, m_valid ? m_pc + 32'd1 : m_target);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #1;
        chk("reset_imem_pc", imem_pc, 32'd0);
        chk("reset_valid", {31'd0, inst_valid}, 32'd0);
        tick(); tick();
        #1 rst_n = 1'b1;

        // Straight-line fetch
        tick(); chk("lit_pc0", inst_pc, 32'd0); chk("lit_out0", inst_out, 32'hA000_0000);
        tick(); chk("lit_pc1", inst_pc, 32'd1);
        tick(); chk("lit_pc2", inst_pc, 32'd2);
        #1 stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_stall_pc", inst_pc, 32'd2);
            chk("lit_stall_out", inst_out, 32'hA000_0002);
        end
        #1 stall = 1'b0;
        tick(); chk("lit_pc3", inst_pc, 32'd3);
        tick(); chk("lit_pc4", inst_pc, 32'd4);

        // Redirect to 8
        #1 begin redirect_valid = 1'b1; redirect_pc = 32'd8; end
        tick();
        #1 redirect_valid = 1'b0;
        chk("lit_bubble_valid", {31'd0, inst_valid}, 32'd0);
        chk("lit_bubble_out", inst_out, 32'd0);
        chk("lit_bubble_pc", inst_pc, 32'd0);
        tick(); chk("lit_pc8", inst_pc, 32'd8); chk("lit_out8", inst_out, 32'hA000_0008);
        tick(); chk("lit_pc9", inst_pc, 32'd9);

        // Redirect together with stall while HELD
        #1 stall = 1'b1;
        tick(); chk("lit_held9", inst_pc, 32'd9);
        #1 begin redirect_valid = 1'b1; redirect_pc = 32'd20; end
        tick();
        #1 redirect_valid = 1'b0;
        chk("lit_bubble2", {31'd0, inst_valid}, 32'd0);
        tick(); chk("lit_pc20", inst_pc, 32'd20);
        tick(); chk("lit_held20", inst_pc, 32'd20);
        #1 stall = 1'b0;
        tick(); chk("lit_pc21", inst_pc, 32'd21);

        // Wrap-around
        #1 begin redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; end
        tick();
        #1 redirect_valid = 1'b0;
        tick(); chk("lit_pc_ff", inst_pc, 32'hFFFF_FFFF);
        tick(); chk("lit_pc_wrap0", inst_pc, 32'd0);
        tick(); chk("lit_pc_wrap1", inst_pc, 32'd1);

        // Mixed stall pattern, model-checked every cycle
        for (int i = 0; i < 30; i++) begin
            #1 stall = (i % 3 == 0) || (i % 7 == 2);
            tick();
        end
        #1 stall = 1'b0;
        tick();

        // Asynchronous reset in the middle of a stall
        #1 stall = 1'b1;
        tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_async_valid", {31'd0, inst_valid}, 32'd0);
        chk("lit_async_imem_pc", imem_pc, 32'd0);
        tick();
        #1 begin rst_n = 1'b1; stall = 1'b0; end
        tick(); chk("lit_restart0", inst_pc, 32'd0);
        tick(); chk("lit_restart1", inst_pc, 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
